// File: rtl/img_pkg.sv
// Shared types for the raster image reader: default pixel width, pixel type,
// coordinate width helper and the reader FSM state encoding.
package img_pkg;

    localparam int PIX_W = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Coordinate counters need at least one bit even for a 1-pixel dimension.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle RAM latency so reads issued ahead
// of a stall are never dropped; head word is presented combinationally.
module pix_skid_fifo #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_occ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_dout = r_mem[r_rd];
    assign o_occ  = r_occ;

endmodule

// File: rtl/image_mem_reader.sv
// Raster-order frame reader: walks the image RAM from BASE_ADDR and streams
// coordinate-tagged pixels over valid/ready with credit-limited read issue.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, one per cycle while credit allows
// DRAIN | all addresses issued, emptying buffer
// DONE  | one-cycle done pulse
module image_mem_reader
    import img_pkg::*;
#(
    parameter int DATA_W    = PIX_W,
    parameter int ADDR_W    = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int BASE_ADDR = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_mem_en,
    output logic [ADDR_W-1:0]         o_mem_addr,
    input  logic [DATA_W-1:0]         i_mem_dout,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [DATA_W-1:0]         o_out_data,
    output logic [coord_w(IMG_W)-1:0] o_out_x,
    output logic [coord_w(IMG_H)-1:0] o_out_y,
    output logic                      o_out_eol,
    output logic                      o_out_last
);

    localparam int X_W    = coord_w(IMG_W);
    localparam int Y_W    = coord_w(IMG_H);
    localparam int TAG_W  = X_W + Y_W + 2;
    localparam int FIFO_W = DATA_W + TAG_W;
    localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

    if (IMG_W < 1 || IMG_H < 1 ||
        longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W))
    begin : g_frame_range_check
        $fatal(1, "image_mem_reader: frame does not fit in the RAM address space");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic                r_inflight;
    logic [TAG_W-1:0]    r_tag;
    logic                w_issue;
    logic                w_pop;
    logic                w_x_last;
    logic                w_frame_last;
    logic [2:0]          w_credit;
    logic [1:0]          w_occ;
    logic [FIFO_W-1:0]   w_head;

    assign w_x_last     = (r_x == X_LAST);
    assign w_frame_last = w_x_last && (r_y == Y_LAST);

    assign o_out_valid = (w_occ != 2'd0);
    assign w_pop       = o_out_valid & i_out_ready;
    // Outstanding words after this cycle: buffered + in flight - leaving now.
    assign w_credit    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_issue && w_frame_last) w_state_next = DRAIN;
            DRAIN:   if (w_pop && o_out_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = 1'b0;
        o_done  = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            RUN: begin
                o_busy  = 1'b1;
                w_issue = (w_credit < 3'd2);
            end
            DRAIN: o_busy = 1'b1;
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_mem_en   = w_issue;
    assign o_mem_addr = r_addr;

    // Counters rewind on the final issue so the next frame starts at the base.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr     <= ADDR_BASE;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= {r_x, r_y, w_x_last, w_frame_last};
                if (w_frame_last) begin
                    r_addr <= ADDR_BASE;
                    r_x    <= '0;
                    r_y    <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_x_last) begin
                        r_x <= '0;
                        r_y <= r_y + Y_W'(1);
                    end else begin
                        r_x <= r_x + X_W'(1);
                    end
                end
            end
        end
    end

    pix_skid_fifo #(
        .W (FIFO_W)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_din  ({i_mem_dout, r_tag}),
        .o_dout (w_head),
        .o_occ  (w_occ)
    );

    assign {o_out_data, o_out_x, o_out_y, o_out_eol, o_out_last} = w_head;

endmodule
